// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: sequences stall/flush controls for a 4-stage
// datapath through init, normal run, data-memory wait and post-trap drain.
`timescale 1ns/1ps
module hazard_ctrl #(
  parameter int INIT_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int PERF_W       = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_use_stall_i,
  input  logic              br_taken_i,
  input  logic              trap_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ack_i,
  output logic              stall_if_ao,
  output logic              stall_id_ao,
  output logic              stall_ex_ao,
  output logic              stall_mem_ao,
  output logic              flush_id_ao,
  output logic              flush_ex_ao,
  output logic              flush_mem_ao,
  output logic              mem_timeout_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam int CNT_MAX = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int WW      = $clog2(MEM_TIMEOUT + 1);

  localparam logic [CW-1:0] INIT_LOAD  = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_MEM_WAIT, S_DRAIN} state_t;

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic [WW-1:0]     r_wait, w_wait_next;
  logic              r_timeout, w_timeout_next;
  logic [PERF_W-1:0] r_stall_cnt;
  logic              w_mem_wait;
  logic              w_run_ev;
  logic              w_any_stall;

  assign w_mem_wait  = dmem_req_i & ~dmem_ack_i;
  assign w_any_stall = stall_if_ao | stall_id_ao | stall_ex_ao | stall_mem_ao;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_INIT;
      r_cnt       <= INIT_LOAD;
      r_wait      <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_wait    <= w_wait_next;
      r_timeout <= w_timeout_next;
      if (w_any_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_wait_next    = r_wait;
    w_timeout_next = r_timeout;
    w_run_ev       = 1'b0;
    stall_if_ao    = 1'b0;
    stall_id_ao    = 1'b0;
    stall_ex_ao    = 1'b0;
    stall_mem_ao   = 1'b0;
    flush_id_ao    = 1'b0;
    flush_ex_ao    = 1'b0;
    flush_mem_ao   = 1'b0;

    case (r_state)
      S_INIT, S_DRAIN: begin
        stall_if_ao  = 1'b1;
        flush_id_ao  = 1'b1;
        flush_ex_ao  = 1'b1;
        flush_mem_ao = 1'b1;
        if (r_cnt == '0) w_state_next = S_RUN;
        else             w_cnt_next   = r_cnt - CW'(1);
      end
      S_RUN: begin
        // A trap outranks a pending memory access, so it is resolved below.
        if (!trap_i && w_mem_wait) begin
          stall_if_ao  = 1'b1;
          stall_id_ao  = 1'b1;
          stall_ex_ao  = 1'b1;
          stall_mem_ao = 1'b1;
          w_wait_next  = WW'(1);
          w_state_next = S_MEM_WAIT;
        end else begin
          w_run_ev = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ack_i) begin
          w_run_ev = 1'b1;
        end else if (r_wait == WAIT_MAX) begin
          w_timeout_next = 1'b1;
          flush_id_ao    = 1'b1;
          flush_ex_ao    = 1'b1;
          flush_mem_ao   = 1'b1;
          w_cnt_next     = DRAIN_LOAD;
          w_state_next   = S_DRAIN;
        end else begin
          stall_if_ao  = 1'b1;
          stall_id_ao  = 1'b1;
          stall_ex_ao  = 1'b1;
          stall_mem_ao = 1'b1;
          w_wait_next  = r_wait + WW'(1);
        end
      end
      default: w_state_next = S_INIT;
    endcase

    // Ordinary run-time hazards, shared by RUN and the ack cycle of MEM_WAIT.
    if (w_run_ev) begin
      w_state_next = S_RUN;
      if (trap_i) begin
        flush_id_ao  = 1'b1;
        flush_ex_ao  = 1'b1;
        flush_mem_ao = 1'b1;
        w_cnt_next   = DRAIN_LOAD;
        w_state_next = S_DRAIN;
      end else if (br_taken_i) begin
        flush_id_ao = 1'b1;
        flush_ex_ao = 1'b1;
      end else if (load_use_stall_i) begin
        stall_if_ao = 1'b1;
        stall_id_ao = 1'b1;
        flush_ex_ao = 1'b1;
      end
    end
  end

  assign mem_timeout_o = r_timeout;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed plus randomized check of hazard_ctrl against a cycle-level
// behavioural model of the stall/flush rules.
`timescale 1ns/1ps
module tb_hazard_ctrl;
  localparam int INIT_C  = 2;
  localparam int DRAIN_C = 2;
  localparam int MT      = 4;
  localparam int PW      = 8;
  localparam int SAT     = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic lu = 1'b0, br = 1'b0, tr = 1'b0, rq = 1'b0, ak = 1'b0;
  logic s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem, tmo;
  logic [PW-1:0] scnt;
  wire  [6:0] dut_vec = {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem};

  int total = 0;
  int bad = 0;

  // Model state: remaining hold (init/drain) cycles, memory wait progress,
  // sticky timeout and saturating stall count.
  int hold_left, waited, stalls;
  bit waiting, timed_out;

  hazard_ctrl #(
    .INIT_CYCLES(INIT_C), .DRAIN_CYCLES(DRAIN_C), .MEM_TIMEOUT(MT), .PERF_W(PW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .load_use_stall_i(lu), .br_taken_i(br), .trap_i(tr),
    .dmem_req_i(rq), .dmem_ack_i(ak),
    .stall_if_ao(s_if), .stall_id_ao(s_id), .stall_ex_ao(s_ex), .stall_mem_ao(s_mem),
    .flush_id_ao(f_id), .flush_ex_ao(f_ex), .flush_mem_ao(f_mem),
    .mem_timeout_o(tmo), .stall_cnt_o(scnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Output vector order: stall if,id,ex,mem, flush id,ex,mem.
  function automatic logic [6:0] model_out();
    if (hold_left > 0)      return 7'b1000111;
    if (waiting && !ak)     return (waited == MT) ? 7'b0000111 : 7'b1111000;
    if (tr)                 return 7'b0000111;
    if (rq && !ak)          return 7'b1111000;
    if (br)                 return 7'b0000110;
    if (lu)                 return 7'b1100010;
    return 7'b0000000;
  endfunction

  task automatic model_reset();
    hold_left = INIT_C;
    waiting   = 1'b0;
    waited    = 0;
    timed_out = 1'b0;
    stalls    = 0;
  endtask

  task automatic model_step();
    logic [6:0] o;
    o = model_out();
    if ((|o[6:3]) && stalls < SAT) stalls++;
    if (hold_left > 0) begin
      hold_left--;
      return;
    end
    if (waiting && !ak) begin
      if (waited == MT) begin
        timed_out = 1'b1;
        waiting   = 1'b0;
        hold_left = DRAIN_C;
      end else begin
        waited++;
      end
      return;
    end
    waiting = 1'b0;
    if (tr) hold_left = DRAIN_C;
    else if (rq && !ak) begin
      waiting = 1'b1;
      waited  = 1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    chk("outs", int'(dut_vec), int'(model_out()));
    chk("timeout", int'(tmo), int'(timed_out));
    chk("stall_cnt", int'(scnt), stalls);
  end

  task automatic drive(input logic l, input logic b, input logic t, input logic r, input logic a);
    @(posedge clk);
    #1;
    lu = l; br = b; tr = t; rq = r; ak = a;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [6:0] ev, input int ec);
    chk({name, "_out"}, int'(dut_vec), int'(ev));
    chk({name, "_cnt"}, int'(scnt), ec);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    lit("reset", 7'b1000111, 0);
    chk("reset_tmo", int'(tmo), 0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    lit("init1", 7'b1000111, 0);
    drive(0, 0, 0, 0, 0); lit("init2", 7'b1000111, 1);
    drive(0, 0, 0, 0, 0); lit("run_idle", 7'b0000000, 2);

    drive(1, 0, 0, 0, 0); lit("load_use", 7'b1100010, 2);
    drive(0, 0, 0, 0, 0); lit("load_use_after", 7'b0000000, 3);

    drive(1, 1, 0, 0, 0); lit("br_over_lu", 7'b0000110, 3);
    drive(0, 0, 0, 0, 0); lit("br_after", 7'b0000000, 3);

    drive(0, 0, 0, 1, 0); lit("mw1", 7'b1111000, 3);
    drive(0, 0, 0, 1, 0); lit("mw2", 7'b1111000, 4);
    drive(0, 0, 0, 1, 0); lit("mw3", 7'b1111000, 5);
    drive(0, 0, 0, 1, 1); lit("mw_ack", 7'b0000000, 6);
    drive(0, 0, 0, 0, 0); lit("mw_done", 7'b0000000, 6);

    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1, 0); lit("to_stall", 7'b1111000, 6 + k);
    end
    drive(0, 0, 0, 1, 0); lit("to_flush", 7'b0000111, 10);
    chk("to_flag_pre", int'(tmo), 0);
    drive(0, 0, 0, 1, 0); lit("to_drain1", 7'b1000111, 10);
    chk("to_flag", int'(tmo), 1);
    drive(0, 0, 0, 1, 0); lit("to_drain2", 7'b1000111, 11);
    drive(0, 0, 0, 0, 0); lit("to_run", 7'b0000000, 12);
    chk("to_sticky", int'(tmo), 1);

    drive(0, 0, 1, 0, 0); lit("trap", 7'b0000111, 12);
    drive(0, 0, 0, 0, 0); lit("trap_drain1", 7'b1000111, 12);
    #2 rst_n = 1'b0;
    #1;
    lit("async_rst", 7'b1000111, 0);
    chk("async_rst_tmo", int'(tmo), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    lit("reinit1", 7'b1000111, 0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!rst_n)                              rst_n = 1'b1;
      else if ($urandom_range(0, 999) == 0)    rst_n = 1'b0;
      lu = ($urandom_range(0, 4) == 0);
      br = ($urandom_range(0, 5) == 0);
      tr = ($urandom_range(0, 24) == 0);
      rq = ($urandom_range(0, 2) == 0);
      ak = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
